// File: rtl/aes_round_ctrl_pkg.sv
// Shared definitions for the AES-128 round sequencer: FSM state encoding,
// default round count and counter widths.
package aes_round_ctrl_pkg;

  localparam int AES_NR_128  = 10;
  localparam int ENC_W       = 6;
  localparam int ROUND_W     = 4;
  // Internal round counter is one bit wider so last-round detection stays exact for NR up to 30.
  localparam int ROUND_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SUB  = 3'd2,
    ST_MIX  = 3'd3,
    ST_CAPT = 3'd4,
    ST_DONE = 3'd5
  } aes_state_t;

  function automatic int capt_step(input int nr);
    return 2 * nr + 1;
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Step counter (enc) and round index for the AES sequencer. enc counts one per
// phase; round advances whenever enc leaves an even step (LOAD or MIX).
module aes_round_counter
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_inc,
  input  logic               i_clr,
  input  logic               i_hold,
  output logic [ENC_W-1:0]   o_enc,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_last_round
);

  localparam int                     CAPT_STEP = capt_step(NR);
  localparam logic [ENC_W-1:0]       CAPT_L    = ENC_W'(CAPT_STEP);
  localparam logic [ROUND_CNT_W-1:0] NR_L      = ROUND_CNT_W'(NR);

  logic [ENC_W-1:0]       r_enc;
  logic [ROUND_CNT_W-1:0] r_round;

  // Saturate at the capture step so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_enc   <= '0;
      r_round <= '0;
    end else if (i_inc && !i_hold && (r_enc != CAPT_L)) begin
      r_enc <= r_enc + 1'b1;
      if (!r_enc[0] && (r_round != NR_L)) begin
        r_round <= r_round + 1'b1;
      end
    end
  end

  assign o_enc        = r_enc;
  assign o_round      = r_round[ROUND_W-1:0];
  assign o_last_round = (r_round == NR_L);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer. Outputs are Moore decodes of the state and
// counter registers. Optional abort port enabled by AES_CTRL_ABORT_EN.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               key_ready,
`ifdef AES_CTRL_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [ENC_W-1:0]   enc,
  output logic [ROUND_W-1:0] round,
  output logic               ld_input,
  output logic               sub_en,
  output logic               key_exp_en,
  output logic               mix_en,
  output logic               addkey_en,
  output logic               out_capture
);

  aes_state_t r_state;
  aes_state_t w_state_nxt;
  logic       r_stall;
  logic       w_stall_nxt;
  logic       w_inc;
  logic       w_clr;
  logic       w_hold;
  logic       w_last_round;
  logic       w_abort;
  logic       w_busy_st;

`ifdef AES_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_busy_st = (r_state == ST_LOAD) || (r_state == ST_SUB) ||
                     (r_state == ST_MIX)  || (r_state == ST_CAPT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= w_stall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall_nxt = 1'b0;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    w_hold      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_clr = 1'b1;
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (key_ready) begin
          w_inc       = 1'b1;
          w_state_nxt = ST_SUB;
        end else begin
          w_hold = 1'b1;
        end
      end
      ST_SUB: begin
        // A SUB cycle re-entered because the key was late is a stall: enables stay low.
        if (key_ready) begin
          w_inc       = 1'b1;
          w_state_nxt = ST_MIX;
        end else begin
          w_hold      = 1'b1;
          w_stall_nxt = 1'b1;
        end
      end
      ST_MIX: begin
        w_inc       = 1'b1;
        w_state_nxt = w_last_round ? ST_CAPT : ST_SUB;
      end
      ST_CAPT: w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_abort && w_busy_st) begin
      w_state_nxt = ST_IDLE;
      w_stall_nxt = 1'b0;
      w_inc       = 1'b0;
      w_clr       = 1'b1;
    end
  end

  aes_round_counter #(
    .NR(NR)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_inc),
    .i_clr        (w_clr),
    .i_hold       (w_hold),
    .o_enc        (enc),
    .o_round      (round),
    .o_last_round (w_last_round)
  );

  assign busy        = w_busy_st;
  assign done        = (r_state == ST_DONE);
  assign ld_input    = (r_state == ST_LOAD);
  assign sub_en      = (r_state == ST_SUB) && !r_stall;
  assign key_exp_en  = (r_state == ST_SUB) && !r_stall;
  assign mix_en      = (r_state == ST_MIX) && !w_last_round;
  assign addkey_en   = (r_state == ST_LOAD) || (r_state == ST_MIX);
  assign out_capture = (r_state == ST_CAPT);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=2 instances share stimulus and are
// checked every cycle against an enc-based behavioural model.
module tb_aes_round_ctrl;

  localparam int NRS [2] = '{10, 2};
`ifdef AES_CTRL_ABORT_EN
  localparam bit HAS_ABORT = 1'b1;
`else
  localparam bit HAS_ABORT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic key_ready = 1'b1;
  logic abort = 1'b0;

  logic       busy_o [2];
  logic       done_o [2];
  logic [5:0] enc_o [2];
  logic [3:0] round_o [2];
  logic       ld_o [2];
  logic       sub_o [2];
  logic       kexp_o [2];
  logic       mix_o [2];
  logic       addk_o [2];
  logic       cap_o [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: a run is just an enc value walking 0..2NR+1, plus a done cycle.
  bit m_act [2];
  bit m_dn [2];
  bit m_stl [2];
  int m_enc [2];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .start(start), .key_ready(key_ready),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_o[0]), .done(done_o[0]), .enc(enc_o[0]), .round(round_o[0]),
    .ld_input(ld_o[0]), .sub_en(sub_o[0]), .key_exp_en(kexp_o[0]), .mix_en(mix_o[0]),
    .addkey_en(addk_o[0]), .out_capture(cap_o[0])
  );

  aes_round_ctrl #(.NR(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .key_ready(key_ready),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_o[1]), .done(done_o[1]), .enc(enc_o[1]), .round(round_o[1]),
    .ld_input(ld_o[1]), .sub_en(sub_o[1]), .key_exp_en(kexp_o[1]), .mix_en(mix_o[1]),
    .addkey_en(addk_o[1]), .out_capture(cap_o[1])
  );

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %0d expected %0d", nm, idx, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) chk_en <= 1'b1;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0; m_dn[i] <= 1'b0; m_stl[i] <= 1'b0; m_enc[i] <= 0;
      end else if (m_dn[i]) begin
        m_dn[i] <= 1'b0; m_enc[i] <= 0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i] <= 1'b1; m_enc[i] <= 0; m_stl[i] <= 1'b0;
        end
      end else if (HAS_ABORT && abort) begin
        m_act[i] <= 1'b0; m_enc[i] <= 0; m_stl[i] <= 1'b0;
      end else if (m_enc[i] == 2 * NRS[i] + 1) begin
        m_act[i] <= 1'b0; m_dn[i] <= 1'b1;
      end else if (m_enc[i] == 0) begin
        if (key_ready) m_enc[i] <= 1;
      end else if (m_enc[i] % 2 == 1) begin
        if (key_ready) begin
          m_enc[i] <= m_enc[i] + 1; m_stl[i] <= 1'b0;
        end else begin
          m_stl[i] <= 1'b1;
        end
      end else begin
        m_enc[i] <= m_enc[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int e, c, r;
        bit a;
        e = m_enc[i];
        c = 2 * NRS[i] + 1;
        a = m_act[i];
        r = (e + 1) / 2;
        if (r > NRS[i]) r = NRS[i];
        chk("busy", i, busy_o[i], a);
        chk("done", i, done_o[i], m_dn[i]);
        chk("enc", i, enc_o[i], e);
        chk("round", i, round_o[i], r);
        chk("ld_input", i, ld_o[i], a && e == 0);
        chk("sub_en", i, sub_o[i], a && (e % 2 == 1) && e < c && !m_stl[i]);
        chk("key_exp_en", i, kexp_o[i], a && (e % 2 == 1) && e < c && !m_stl[i]);
        chk("mix_en", i, mix_o[i], a && e > 0 && (e % 2 == 0) && e < 2 * NRS[i]);
        chk("addkey_en", i, addk_o[i], a && (e % 2 == 0));
        chk("out_capture", i, cap_o[i], a && e == c);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_o[0] || busy_o[1] || done_o[0] || done_o[1]) && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) chk("wait_idle_timeout", 0, 1, 0);
  endtask

  task automatic wait_enc0(input int v);
    int k;
    k = 0;
    while (!(busy_o[0] && enc_o[0] == v) && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) chk("wait_enc_timeout", 0, v, -1);
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done0(input int t0, input int exp_lat, input string nm);
    int k;
    k = 0;
    while (!done_o[0] && k < 200) begin
      @(negedge clk); k++;
    end
    chk(nm, 0, cyc - t0, exp_lat);
  endtask

  initial begin
    int t0, k, cap_enc0, mix20, loads, dones;
    bit prev_busy;
    int seq2 [$];
    int mix2 [$];
    int exp_seq [6] = '{0, 1, 2, 3, 4, 5};

    // Reset held two cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 0, busy_o[0], 0);
    chk("reset_enc", 0, enc_o[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Uninterrupted run: latency, capture step, last-round mix suppression.
    key_ready = 1'b1;
    wait_idle();
    pulse_start(t0);
    cap_enc0 = -1; mix20 = -1; k = 0;
    while (!done_o[0] && k < 100) begin
      if (cap_o[0]) cap_enc0 = enc_o[0];
      if (enc_o[0] == 20 && busy_o[0]) mix20 = mix_o[0];
      if (busy_o[1]) seq2.push_back(enc_o[1]);
      if (mix_o[1]) mix2.push_back(enc_o[1]);
      @(negedge clk); k++;
    end
    chk("done_latency", 0, cyc - t0, 23);
    chk("capture_enc", 0, cap_enc0, 21);
    chk("mix_at_enc20", 0, mix20, 0);
    chk("nr2_seq_len", 1, seq2.size(), 6);
    for (int i = 0; i < 6 && i < seq2.size(); i++) chk("nr2_seq", 1, seq2[i], exp_seq[i]);
    chk("nr2_mix_count", 1, mix2.size(), 1);
    if (mix2.size() > 0) chk("nr2_mix_enc", 1, mix2[0], 2);

    // Key stalls: 3 cycles in LOAD and 3 in round-4 SUB.
    wait_idle();
    pulse_start(t0);
    key_ready = 1'b0;
    repeat (3) @(negedge clk);
    key_ready = 1'b1;
    wait_enc0(7);
    key_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_enc", 0, enc_o[0], 7);
    chk("stall_round", 0, round_o[0], 4);
    chk("stall_sub_en", 0, sub_o[0], 0);
    key_ready = 1'b1;
    wait_done0(t0, 29, "stall_latency");

    // start held high: runs only restart from IDLE.
    wait_idle();
    start = 1'b1;
    prev_busy = 1'b0; loads = 0; dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_o[0] && !prev_busy) loads++;
      if (done_o[0]) dones++;
      prev_busy = busy_o[0];
    end
    start = 1'b0;
    chk("held_start_loads", 0, loads, 3);
    chk("held_start_dones", 0, dones, 2);

    // Reset mid-round.
    wait_idle();
    pulse_start(t0);
    wait_enc0(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 0, busy_o[0], 0);
    chk("midrst_enc", 0, enc_o[0], 0);
    chk("midrst_round", 0, round_o[0], 0);

`ifdef AES_CTRL_ABORT_EN
    wait_idle();
    pulse_start(t0);
    wait_enc0(9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 0, busy_o[0], 0);
    chk("abort_enc", 0, enc_o[0], 0);
    wait_idle();
    pulse_start(t0);
    wait_done0(t0, 23, "post_abort_latency");
`endif

    // Randomised traffic, checked cycle-by-cycle by the model.
    wait_idle();
    for (int n = 0; n < 3000; n++) begin
      start     = ($urandom % 8) == 0;
      key_ready = ($urandom % 4) != 0;
      abort     = ($urandom % 64) == 0;
      rst       = ($urandom % 500) == 0;
      @(negedge clk);
    end
    start = 1'b0; key_ready = 1'b1; abort = 1'b0; rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
